// File: rtl/mips_pkg.sv
// Shared MIPS memory-path definitions: opcodes, store FSM states and lane constants.
// Used by store_unit, store_align and the register-file load merge path.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_LB  = 6'b100000,
    OP_LH  = 6'b100001,
    OP_LWL = 6'b100010,
    OP_LW  = 6'b100011,
    OP_LBU = 6'b100100,
    OP_LHU = 6'b100101,
    OP_LWR = 6'b100110,
    OP_SB  = 6'b101000,
    OP_SH  = 6'b101001,
    OP_SWL = 6'b101010,
    OP_SW  = 6'b101011,
    OP_SWR = 6'b101110
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ERR   = 2'd2
  } state_e;

  localparam int          LANE_W     = 8;
  localparam int          NUM_LANES  = 4;
  localparam logic [3:0]  BE_NONE    = 4'b0000;
  localparam logic [3:0]  BE_ALL     = 4'b1111;
  localparam logic [3:0]  BE_LO_HALF = 4'b0011;
  localparam logic [3:0]  BE_HI_HALF = 4'b1100;

endpackage

// File: rtl/store_unit_if.sv
// Store request + Avalon data-memory write port bundle.
// slave = store_unit view, master = CPU/memory (testbench) view.
interface store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       rt_data;
  logic              done;
  logic              addr_error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;

  modport slave (
    input  req_valid, opcode, addr, rt_data, avm_waitrequest,
    output req_ready, done, addr_error, avm_address, avm_write,
           avm_writedata, avm_byteenable
  );

  modport master (
    output req_valid, opcode, addr, rt_data, avm_waitrequest,
    input  req_ready, done, addr_error, avm_address, avm_write,
           avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/store_align.sv
// Combinational lane mapper: (opcode, addr[1:0], rt) -> byteenable/writedata/misaligned.
// SWL/SWR decode only exists when STORE_UNALIGNED_EN is defined.
module store_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  k_i,
  input  logic [31:0] rt_data_i,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  output logic        misaligned_o,
  output logic        is_store_o
);

  // Decode the store flavour and steer rt into little-endian lanes
  always_comb begin
    byteenable_o = BE_NONE;
    writedata_o  = 32'h0000_0000;
    misaligned_o = 1'b0;
    is_store_o   = 1'b0;
    case (opcode_i)
      OP_SB: begin
        is_store_o   = 1'b1;
        byteenable_o = 4'b0001 << k_i;
        writedata_o  = {NUM_LANES{rt_data_i[LANE_W-1:0]}};
      end
      OP_SH: begin
        is_store_o   = 1'b1;
        byteenable_o = k_i[1] ? BE_HI_HALF : BE_LO_HALF;
        writedata_o  = {2{rt_data_i[15:0]}};
        misaligned_o = k_i[0];
      end
      OP_SW: begin
        is_store_o   = 1'b1;
        byteenable_o = BE_ALL;
        writedata_o  = rt_data_i;
        misaligned_o = (k_i != 2'b00);
      end
`ifdef STORE_UNALIGNED_EN
      // Partial-word stores never fault; the lane pattern absorbs the offset
      OP_SWL: begin
        is_store_o   = 1'b1;
        byteenable_o = BE_ALL >> (2'd3 - k_i);
        writedata_o  = rt_data_i >> {(2'd3 - k_i), 3'b000};
      end
      OP_SWR: begin
        is_store_o   = 1'b1;
        byteenable_o = BE_ALL << k_i;
        writedata_o  = rt_data_i << {k_i, 3'b000};
      end
`endif
      default: begin
        is_store_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts CPU store requests and issues Avalon writes, flagging misaligned stores.
// Optional SWL/SWR support via the STORE_UNALIGNED_EN macro (handled in store_align).
module store_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int ERR_HOLD = 1
) (
  input  logic         clk,
  input  logic         reset,
  store_unit_if.slave  bus
);

  localparam logic [3:0] ERR_LAST = 4'(ERR_HOLD - 1);

  state_e            state_q, state_d;
  logic [3:0]        err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic              al_misaligned;
  logic              al_is_store;

  logic              req_ready_s;
  logic              done_s;
  logic              addr_error_s;
  logic              avm_write_s;
  logic              take_store;
  logic              take_bad;

  store_align u_align (
    .opcode_i     (bus.opcode),
    .k_i          (bus.addr[1:0]),
    .rt_data_i    (bus.rt_data),
    .byteenable_o (al_be),
    .writedata_o  (al_wdata),
    .misaligned_o (al_misaligned),
    .is_store_o   (al_is_store)
  );

  assign take_store = bus.req_valid & req_ready_s & al_is_store & ~al_misaligned;
  assign take_bad   = bus.req_valid & req_ready_s & al_is_store &  al_misaligned;

  // State and holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      err_cnt_q <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      be_q      <= BE_NONE;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  // Next-state: capture in IDLE or in the accepting WRITE cycle (zero-bubble chaining)
  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    if (take_store) begin
      addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
      wdata_d = al_wdata;
      be_d    = al_be;
    end else begin
      addr_d  = addr_q;
    end
    case (state_q)
      IDLE: begin
        if (take_store) begin
          state_d = WRITE;
        end else if (take_bad) begin
          state_d   = ERR;
          err_cnt_d = ERR_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (bus.avm_waitrequest) begin
          state_d = WRITE;
        end else if (take_store) begin
          state_d = WRITE;
        end else if (take_bad) begin
          state_d   = ERR;
          err_cnt_d = ERR_LAST;
        end else begin
          state_d = IDLE;
        end
      end
      ERR: begin
        if (err_cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          err_cnt_d = err_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from state; done/ready follow waitrequest in the accepting cycle
  always_comb begin
    req_ready_s  = 1'b0;
    done_s       = 1'b0;
    addr_error_s = 1'b0;
    avm_write_s  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_s = 1'b1;
      end
      WRITE: begin
        avm_write_s = 1'b1;
        if (!bus.avm_waitrequest) begin
          done_s      = 1'b1;
          req_ready_s = 1'b1;
        end else begin
          done_s      = 1'b0;
          req_ready_s = 1'b0;
        end
      end
      ERR: begin
        addr_error_s = 1'b1;
      end
      default: begin
        req_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.req_ready      = req_ready_s;
  assign bus.done           = done_s;
  assign bus.addr_error     = addr_error_s;
  assign bus.avm_write      = avm_write_s;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = wdata_q;
  assign bus.avm_byteenable = be_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit; expectations follow STORE_UNALIGNED_EN.
module tb_store_unit;
  import mips_pkg::*;

  localparam int ERR_HOLD = 3;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  store_unit_if #(.ADDR_W(32)) bus ();

  store_unit #(.ADDR_W(32), .ERR_HOLD(ERR_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {avm_write, done, req_ready, addr_error}
  wire [3:0] ctl = {bus.avm_write, bus.done, bus.req_ready, bus.addr_error};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic w);
    bus.req_valid       = v;
    bus.opcode          = op;
    bus.addr            = a;
    bus.rt_data         = d;
    bus.avm_waitrequest = w;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, 6'd0, 32'd0, 32'd0, 1'b0);
    #2;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 4'b0010); end
    checks++;
    if ({bus.avm_address, bus.avm_writedata, bus.avm_byteenable} !== 68'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h/%h/%b expected zeros", bus.avm_address, bus.avm_writedata, bus.avm_byteenable);
    end
    #10;
    reset = 1'b1;
  endtask

  task automatic test_sb;
    tick;
    drive(1'b1, OP_SB, 32'h0000_1003, 32'h0000_00A5, 1'b0);
    #1;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL sb_ready: got %b expected %b", ctl, 4'b0010); end
    tick;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b1110) begin errors++; $display("FAIL sb_ctl: got %b expected %b", ctl, 4'b1110); end
    checks++;
    if ({bus.avm_address, bus.avm_byteenable, bus.avm_writedata} !== {32'h0000_1000, 4'b1000, 32'hA5A5_A5A5}) begin
      errors++;
      $display("FAIL sb_bus: got %h/%b/%h expected 00001000/1000/a5a5a5a5", bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
    end
    tick;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL sb_idle: got %b expected %b", ctl, 4'b0010); end
  endtask

  task automatic test_sh_stall;
    tick;
    drive(1'b1, OP_SH, 32'h0000_2002, 32'h1234_BEEF, 1'b1);
    tick;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== 4'b1000) begin errors++; $display("FAIL sh_stall_ctl[%0d]: got %b expected %b", i, ctl, 4'b1000); end
      checks++;
      if ({bus.avm_address, bus.avm_byteenable, bus.avm_writedata} !== {32'h0000_2000, 4'b1100, 32'hBEEF_BEEF}) begin
        errors++;
        $display("FAIL sh_stall_bus[%0d]: got %h/%b/%h expected 00002000/1100/beefbeef", i, bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
      end
      tick;
    end
    bus.avm_waitrequest = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b1110) begin errors++; $display("FAIL sh_accept: got %b expected %b", ctl, 4'b1110); end
    tick;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL sh_idle: got %b expected %b", ctl, 4'b0010); end
  endtask

  task automatic test_misaligned;
    tick;
    drive(1'b1, OP_SW, 32'h0000_3001, 32'hCAFE_F00D, 1'b0);
    tick;
    bus.req_valid = 1'b0;
    for (int i = 0; i < ERR_HOLD; i++) begin
      #1;
      checks++;
      if (ctl !== 4'b0001) begin errors++; $display("FAIL sw_err[%0d]: got %b expected %b", i, ctl, 4'b0001); end
      tick;
    end
    #1;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL sw_err_exit: got %b expected %b", ctl, 4'b0010); end
  endtask

  task automatic test_back_to_back;
    tick;
    drive(1'b1, OP_SW, 32'h0000_0040, 32'h1111_1111, 1'b0);
    tick;
    drive(1'b1, OP_SW, 32'h0000_0044, 32'h2222_2222, 1'b0);
    #1;
    checks++;
    if ({ctl, bus.avm_address, bus.avm_writedata} !== {4'b1110, 32'h0000_0040, 32'h1111_1111}) begin
      errors++;
      $display("FAIL b2b_first: got %b/%h/%h expected 1110/00000040/11111111", ctl, bus.avm_address, bus.avm_writedata);
    end
    tick;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if ({ctl, bus.avm_address, bus.avm_writedata} !== {4'b1110, 32'h0000_0044, 32'h2222_2222}) begin
      errors++;
      $display("FAIL b2b_second: got %b/%h/%h expected 1110/00000044/22222222", ctl, bus.avm_address, bus.avm_writedata);
    end
    tick;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL b2b_idle: got %b expected %b", ctl, 4'b0010); end
  endtask

  task automatic test_reset_mid_write;
    tick;
    drive(1'b1, OP_SW, 32'h0000_0060, 32'hDEAD_BEEF, 1'b1);
    tick;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b1000) begin errors++; $display("FAIL rst_pre: got %b expected %b", ctl, 4'b1000); end
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL rst_async: got %b expected %b", ctl, 4'b0010); end
    tick;
    reset = 1'b1;
    bus.avm_waitrequest = 1'b0;
    tick;
    checks++;
    if ({ctl, bus.avm_address} !== {4'b0010, 32'h0000_0000}) begin
      errors++;
      $display("FAIL rst_after: got %b/%h expected 0010/00000000", ctl, bus.avm_address);
    end
  endtask

  task automatic test_unknown_and_swl;
    tick;
    drive(1'b1, OP_LW, 32'h0000_7000, 32'h0BAD_0BAD, 1'b0);
    tick;
    bus.req_valid = 1'b0;
    #1;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL unknown_op: got %b expected %b", ctl, 4'b0010); end
    tick;
    drive(1'b1, OP_SWL, 32'h0000_5001, 32'hAABB_CCDD, 1'b0);
    tick;
    bus.req_valid = 1'b0;
    #1;
`ifdef STORE_UNALIGNED_EN
    checks++;
    if ({ctl, bus.avm_address, bus.avm_byteenable, bus.avm_writedata[15:0]} !== {4'b1110, 32'h0000_5000, 4'b0011, 16'hAABB}) begin
      errors++;
      $display("FAIL swl_on: got %b/%h/%b/%h expected 1110/00005000/0011/aabb", ctl, bus.avm_address, bus.avm_byteenable, bus.avm_writedata[15:0]);
    end
`else
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL swl_off: got %b expected %b", ctl, 4'b0010); end
`endif
    tick;
    checks++;
    if (ctl !== 4'b0010) begin errors++; $display("FAIL swl_idle: got %b expected %b", ctl, 4'b0010); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_sb();
    test_sh_stall();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_write();
    test_unknown_and_swl();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Store-side counterpart of the register-file load merge path.
- Accepts one store request per handshake from the CPU: opcode, byte address and rt value.
- Drives the Avalon-style data-memory write port: word address, lane-aligned writedata and byteenable.
- Holds the request stable across waitrequest stalls and flags misaligned stores instead of issuing them.

Parameters:
- ADDR_W, 32, byte-address width.
- ERR_HOLD, 1, cycles addr_error stays high after a misaligned request (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request this cycle.
- opcode  in  6  MIPS opcode of the store.
- addr  in  ADDR_W  effective byte address.
- rt_data  in  32  register value to store.
- done  out  1  one-cycle pulse when the write is accepted by memory.
- addr_error  out  1  misaligned store detected; request dropped.
- avm_address  out  ADDR_W  word-aligned address (addr with bits [1:0] cleared).
- avm_write  out  1  write strobe.
- avm_writedata  out  32  lane-aligned data.
- avm_byteenable  out  4  bit i enables writedata[8i+7:8i].
- avm_waitrequest  in  1  memory stall.

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0 except req_ready=1; holding registers cleared.
- Opcodes (package constants): SB=101000, SH=101001, SW=101011, SWL=101010, SWR=101110.
- Any other opcode accepted with req_valid is ignored: no write, no done, no error.
- Lane mapping is little-endian; k = addr[1:0].
- SB: byteenable = 1<<k; writedata = rt_data[7:0] replicated into all four lanes.
- SH: k=0 gives 0011 with data {rt[15:0],rt[15:0]}; k=2 gives 1100 with the same data; k odd is misaligned.
- SW: k must be 0; byteenable 1111; writedata = rt_data.
- States:
  - IDLE: req_ready=1. On handshake with a valid aligned store, register the computed address/data/byteenable and go to WRITE.
  - Misaligned request: go to ERR.
  - WRITE: avm_write=1; outputs stable while waitrequest=1. The cycle waitrequest=0 is the accepting cycle: done=1 that cycle, then return to IDLE.
  - Back-to-back: req_ready=1 in the accepting cycle, so a new request can be captured in that same cycle and the unit goes straight to WRITE again (zero bubble).
  - ERR: addr_error=1 for ERR_HOLD cycles; req_ready=0; no bus activity; then IDLE.
- Latency: request handshake at cycle N gives avm_write=1 from cycle N+1. done is asserted in the first cycle of WRITE where waitrequest=0.
- waitrequest high indefinitely: stay in WRITE with no timeout.
- Reset mid-WRITE: write aborted immediately; avm_write drops asynchronously.
- req_valid with req_ready=0 has no effect; the requester must hold it.

Optional Feature:
- Macro: STORE_UNALIGNED_EN.
- Defined: SWL and SWR are supported, and no alignment check applies to them.
  - SWL: byteenable = (1<<(k+1))-1; writedata = rt_data >> 8*(3-k).
  - SWR: byteenable = 4'b1111<<k; writedata = rt_data << 8k.
- Undefined: SWL/SWR are treated as unknown opcodes (ignored).

Decomposition:
- Package mips_pkg holds:
  - opcode enum (load and store values, shared with the register file);
  - state enum {IDLE, WRITE, ERR};
  - lane constants.
- One combinational sub-module, store_align, maps (opcode, k, rt_data) to (byteenable, writedata, misaligned, is_store).
- store_unit owns the FSM and holding registers.

Test Plan:
- SB, addr=0x1003, rt=0x000000A5, waitrequest=0 → cycle N+1: avm_address=0x1000, byteenable=1000, writedata=0xA5A5A5A5, done=1.
- SH, addr=0x2002, rt=0x1234BEEF, waitrequest high for 3 cycles → outputs stable for 3 cycles: byteenable=1100, writedata=0xBEEFBEEF; done in the 4th WRITE cycle only.
- SW, addr=0x3001 → addr_error=1 for ERR_HOLD cycles, avm_write never asserted, req_ready=0 throughout.
- Two SW requests back-to-back (0x40→0x11111111, 0x44→0x22222222), waitrequest=0 → two consecutive write cycles, two done pulses, no idle gap.
- Reset asserted during a stalled SW → avm_write=0 immediately; after release, req_ready=1 and done=0.
- With STORE_UNALIGNED_EN, SWL addr=0x5001 rt=0xAABBCCDD → byteenable=0011, writedata[15:0]=0xAABB.
- Same SWL without the macro → no write, no error.
